vis_centroid_overlay: RTL and testbench

//  Streaming video stage placed directly upstream of the HDMI output logger/encoder.

---
 rtl/vis_overlay_pkg.sv | 24 ++
 rtl/vis_pos_counter.sv | 68 ++++++
 rtl/vis_centroid_overlay.sv | 206 ++++++++++++++++++++
 tb/tb_vis_centroid_overlay.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vis_overlay_pkg.sv
// Shared types, constants and helpers for the vis_* video overlay stages.
// Optional feature macro used by the overlay top: CENTROID_BBOX_EN.
package vis_overlay_pkg;

    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [23:0]        rgb_t;

    // Pure red marker unless the instance overrides it.
    localparam rgb_t   MARK_RGB_DEF = 24'hFF0000;

    // Counters saturate here instead of wrapping.
    localparam coord_t COORD_MAX    = '1;

    // True when |diff| <= lim. diff is the signed difference of two unsigned coords.
    function automatic logic abs_le(input logic signed [COORD_W:0] diff,
                                    input logic [COORD_W-1:0]      lim);
        logic signed [COORD_W:0] l;
        l = $signed({1'b0, lim});
        return (diff <= l) && (diff >= -l);
    endfunction

endpackage

// File: rtl/vis_pos_counter.sv
// Pixel position tracker for vis_* stages: derives the frame start from the
// vsync edge, counts x within a de run and y per de falling edge, and raises
// frame_lock once a frame start has been seen since reset.
module vis_pos_counter
    import vis_overlay_pkg::*;
#(
    parameter logic VS_ACT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_i,
    input  logic               vsync_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               fs_o,
    output logic               frame_lock_o
);

    logic               vs_q;
    logic               de_q;
    logic               lock_q, lock_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    // Frame start is the edge into the active vsync level.
    assign fs_o         = (vsync_i == VS_ACT) && (vs_q != VS_ACT);
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign frame_lock_o = lock_q;

    // Next-state for the position counters; frame start overrides everything.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        lock_d = lock_q;
        if (de_i) begin
            x_d = (x_q == COORD_MAX) ? x_q : x_q + 1'b1;
        end else begin
            x_d = '0;
        end
        if (de_q && !de_i && (y_q != COORD_MAX)) begin
            y_d = y_q + 1'b1;
        end
        if (fs_o) begin
            x_d    = '0;
            y_d    = '0;
            lock_d = 1'b1;
        end
    end

    // Edge-detect history and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            lock_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            vs_q   <= vsync_i;
            de_q   <= de_i;
            lock_q <= lock_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

endmodule

// File: rtl/vis_centroid_overlay.sv
// Centroid crosshair overlay placed just ahead of the HDMI encoder.
// Centroid updates are buffered in a pending register and only become visible
// at the next frame start, so the marker never tears mid-frame.
// Optional feature macro: CENTROID_BBOX_EN adds a bounding-box outline.
module vis_centroid_overlay
    import vis_overlay_pkg::*;
#(
    parameter int          H_RES    = 1280,
    parameter int          V_RES    = 720,
    parameter int          ARM      = 8,
    parameter logic [23:0] MARK_RGB = MARK_RGB_DEF,
    parameter logic        VS_ACT   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [23:0]        pixel_in,
    input  logic [COORD_W-1:0] cent_x,
    input  logic [COORD_W-1:0] cent_y,
    input  logic               cent_valid,
`ifdef CENTROID_BBOX_EN
    input  logic [COORD_W-1:0] bbox_x0,
    input  logic [COORD_W-1:0] bbox_y0,
    input  logic [COORD_W-1:0] bbox_x1,
    input  logic [COORD_W-1:0] bbox_y1,
`endif
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [23:0]        pixel_out
);

    localparam logic [COORD_W:0]   H_LIM = H_RES[COORD_W:0];
    localparam logic [COORD_W:0]   V_LIM = V_RES[COORD_W:0];
    localparam logic [COORD_W-1:0] ARM_L = ARM[COORD_W-1:0];

    logic [COORD_W-1:0] x, y;
    logic               fs, frame_lock;

    vis_pos_counter #(.VS_ACT(VS_ACT)) u_pos (
        .clk          (clk),
        .rst          (rst),
        .de_i         (de_in),
        .vsync_i      (vsync_in),
        .x_o          (x),
        .y_o          (y),
        .fs_o         (fs),
        .frame_lock_o (frame_lock)
    );

    // Pending (latest strobe) and shadow (in use for this frame) coordinates.
    logic [COORD_W-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
    logic               pend_vld_q, pend_vld_d;
    logic               marker_en_q, marker_en_d;
`ifdef CENTROID_BBOX_EN
    logic [COORD_W-1:0] pend_b_q [4];
    logic [COORD_W-1:0] pend_b_d [4];
    logic [COORD_W-1:0] sh_b_q   [4];
    logic [COORD_W-1:0] sh_b_d   [4];
    logic [COORD_W-1:0] bbox_in  [4];
    assign bbox_in[0] = bbox_x0;
    assign bbox_in[1] = bbox_y0;
    assign bbox_in[2] = bbox_x1;
    assign bbox_in[3] = bbox_y1;
`endif

    // Strobes land in pending; frame start copies to shadow, a coincident strobe going straight through.
    always_comb begin
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_vld_d  = pend_vld_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        marker_en_d = marker_en_q;
`ifdef CENTROID_BBOX_EN
        pend_b_d    = pend_b_q;
        sh_b_d      = sh_b_q;
`endif
        if (cent_valid) begin
            pend_x_d   = cent_x;
            pend_y_d   = cent_y;
            pend_vld_d = 1'b1;
`ifdef CENTROID_BBOX_EN
            pend_b_d   = bbox_in;
`endif
        end
        if (fs) begin
            if (cent_valid) begin
                sh_x_d      = cent_x;
                sh_y_d      = cent_y;
                marker_en_d = 1'b1;
`ifdef CENTROID_BBOX_EN
                sh_b_d      = bbox_in;
`endif
            end else if (pend_vld_q) begin
                sh_x_d      = pend_x_q;
                sh_y_d      = pend_y_q;
                marker_en_d = 1'b1;
`ifdef CENTROID_BBOX_EN
                sh_b_d      = pend_b_q;
`endif
            end
        end
    end

    // Coordinate register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_vld_q  <= 1'b0;
            sh_x_q      <= '0;
            sh_y_q      <= '0;
            marker_en_q <= 1'b0;
`ifdef CENTROID_BBOX_EN
            pend_b_q    <= '{default: '0};
            sh_b_q      <= '{default: '0};
`endif
        end else begin
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_vld_q  <= pend_vld_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            marker_en_q <= marker_en_d;
`ifdef CENTROID_BBOX_EN
            pend_b_q    <= pend_b_d;
            sh_b_q      <= sh_b_d;
`endif
        end
    end

    // Hit detection against the current position. Signed differences make the
    // arms clip at the frame edges rather than wrap.
    logic signed [COORD_W:0] dx, dy;
    logic                    draw_en, hit_cross, hit_box;

    assign dx        = $signed({1'b0, x}) - $signed({1'b0, sh_x_q});
    assign dy        = $signed({1'b0, y}) - $signed({1'b0, sh_y_q});
    assign draw_en   = de_in && frame_lock && marker_en_q
                       && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    assign hit_cross = draw_en && (((dx == '0) && abs_le(dy, ARM_L))
                                || ((dy == '0) && abs_le(dx, ARM_L)));

`ifdef CENTROID_BBOX_EN
    logic box_ok, on_v, on_h;
    assign box_ok  = (sh_b_q[0] <= sh_b_q[2]) && (sh_b_q[1] <= sh_b_q[3]);
    assign on_v    = ((x == sh_b_q[0]) || (x == sh_b_q[2])) && (y >= sh_b_q[1]) && (y <= sh_b_q[3]);
    assign on_h    = ((y == sh_b_q[1]) || (y == sh_b_q[3])) && (x >= sh_b_q[0]) && (x <= sh_b_q[2]);
    assign hit_box = draw_en && box_ok && (on_v || on_h);
`else
    assign hit_box = 1'b0;
`endif

    // Two-stage output pipe: stage 1 holds inputs and hit flags, stage 2 the colour mux.
    logic        de_s1_q, hs_s1_q, vs_s1_q, hit_s1_q, box_s1_q;
    logic [23:0] pix_s1_q;
    logic        de_o_q, hs_o_q, vs_o_q;
    logic [23:0] pix_o_q, pix_o_d;

    // Colour select: crosshair wins over the rectangle.
    always_comb begin
        pix_o_d = pix_s1_q;
        if (hit_s1_q) begin
            pix_o_d = MARK_RGB;
        end else if (box_s1_q) begin
            pix_o_d = MARK_RGB ^ 24'hFFFFFF;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            pix_s1_q <= '0;
            hit_s1_q <= 1'b0;
            box_s1_q <= 1'b0;
            de_o_q   <= 1'b0;
            hs_o_q   <= 1'b0;
            vs_o_q   <= 1'b0;
            pix_o_q  <= '0;
        end else begin
            de_s1_q  <= de_in;
            hs_s1_q  <= hsync_in;
            vs_s1_q  <= vsync_in;
            pix_s1_q <= pixel_in;
            hit_s1_q <= hit_cross;
            box_s1_q <= hit_box;
            de_o_q   <= de_s1_q;
            hs_o_q   <= hs_s1_q;
            vs_o_q   <= vs_s1_q;
            pix_o_q  <= pix_o_d;
        end
    end

    assign de_out    = de_o_q;
    assign hsync_out = hs_o_q;
    assign vsync_out = vs_o_q;
    assign pixel_out = pix_o_q;

endmodule

// File: tb/tb_vis_centroid_overlay.sv
// Bench for vis_centroid_overlay: two instances (ARM=2 and ARM=4) on a 64x64
// raster share one stimulus stream; a frame-level model predicts every output.
module tb_vis_centroid_overlay;

    localparam int          HR   = 64;
    localparam int          VR   = 64;
    localparam logic [23:0] MARK = 24'hFF0000;
    localparam logic [23:0] BOXC = 24'h00FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, cent_valid = 1'b0;
    logic [23:0] pixel_in = '0;
    logic [10:0] cent_x = '0, cent_y = '0;
`ifdef CENTROID_BBOX_EN
    logic [10:0] bbox_x0 = '0, bbox_y0 = '0, bbox_x1 = '0, bbox_y1 = '0;
`endif
    logic        de_a, hs_a, vs_a, de_b, hs_b, vs_b;
    logic [23:0] pix_a, pix_b;

    vis_centroid_overlay #(.H_RES(HR), .V_RES(VR), .ARM(2)) dut_a (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_in(pixel_in), .cent_x(cent_x), .cent_y(cent_y), .cent_valid(cent_valid),
`ifdef CENTROID_BBOX_EN
        .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
`endif
        .de_out(de_a), .hsync_out(hs_a), .vsync_out(vs_a), .pixel_out(pix_a)
    );

    vis_centroid_overlay #(.H_RES(HR), .V_RES(VR), .ARM(4)) dut_b (
        .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pixel_in(pixel_in), .cent_x(cent_x), .cent_y(cent_y), .cent_valid(cent_valid),
`ifdef CENTROID_BBOX_EN
        .bbox_x0(bbox_x0), .bbox_y0(bbox_y0), .bbox_x1(bbox_x1), .bbox_y1(bbox_y1),
`endif
        .de_out(de_b), .hsync_out(hs_b), .vsync_out(vs_b), .pixel_out(pix_b)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         failures = 0;
    logic [26:0] exp_a_q[$];
    logic [26:0] exp_b_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: which centroid/box applies to the current frame, and
    // whether a marker may be shown at all.
    bit m_lock, m_ever, m_pend, m_prev_vs;
    int m_sx, m_sy, m_px, m_py;
    int m_sb[4];
    int m_pb[4];

    // This cycle's centroid strobe, fed to both the DUT and the model.
    bit cv_fire;
    int cv_x, cv_y;
    int cv_b[4];

    // Two strobe slots: (line, column) at which each fires; line -1 = vertical blank.
    bit sch_on[2];
    int sch_l[2], sch_c[2], sch_x[2], sch_y[2];
    int sch_b[2][4];

    int obs_ma, obs_mb, obs_box, exp_ma, exp_mb, exp_box;

    function automatic logic [23:0] exp_pix(input int arm, input bit de, input int x, input int y,
                                            input logic [23:0] pix);
        if (!(de && m_lock && m_ever && x < HR && y < VR)) return pix;
        if ((x == m_sx && y - m_sy <= arm && m_sy - y <= arm) ||
            (y == m_sy && x - m_sx <= arm && m_sx - x <= arm)) return MARK;
`ifdef CENTROID_BBOX_EN
        if (m_sb[0] <= m_sb[2] && m_sb[1] <= m_sb[3] &&
            (((x == m_sb[0] || x == m_sb[2]) && y >= m_sb[1] && y <= m_sb[3]) ||
             ((y == m_sb[1] || y == m_sb[3]) && x >= m_sb[0] && x <= m_sb[2]))) return BOXC;
`endif
        return pix;
    endfunction

    function automatic logic [23:0] rnd_pix();
        logic [23:0] p;
        p = 24'($urandom);
        p[23] = 1'b0;
        if (p == BOXC) p = '0;
        return p;
    endfunction

    // ---------------- driver ----------------
    task automatic do_reset(input int cycles);
        rst = 1'b1;
        cent_valid = 1'b0;
        cv_fire = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_out_a", {5'd0, de_a, hs_a, vs_a, pix_a}, 32'd0);
            check_val("rst_out_b", {5'd0, de_b, hs_b, vs_b, pix_b}, 32'd0);
        end
        rst = 1'b0;
        m_lock = 0; m_ever = 0; m_pend = 0; m_prev_vs = 0;
        m_sx = 0; m_sy = 0; m_px = 0; m_py = 0;
        for (int k = 0; k < 4; k++) begin m_sb[k] = 0; m_pb[k] = 0; end
        exp_a_q.delete();
        exp_b_q.delete();
        exp_a_q.push_back('0);
        exp_b_q.push_back('0);
    endtask

    task automatic sched(input int s, input int l, input int c, input int x, input int y);
        sch_on[s] = 1; sch_l[s] = l; sch_c[s] = c; sch_x[s] = x; sch_y[s] = y;
        sch_b[s][0] = 10; sch_b[s][1] = 0; sch_b[s][2] = 0; sch_b[s][3] = 0;
    endtask

    task automatic maybe_fire(input int l, input int c);
        for (int s = 0; s < 2; s++) begin
            if (sch_on[s] && sch_l[s] == l && sch_c[s] == c) begin
                cv_fire = 1; cv_x = sch_x[s]; cv_y = sch_y[s];
                for (int k = 0; k < 4; k++) cv_b[k] = sch_b[s][k];
                sch_on[s] = 0;
            end
        end
    endtask

    // One pixel clock: drive, predict, advance the model, then compare the
    // output that was predicted two cycles earlier.
    task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] pix,
                        input int x, input int y);
        logic [26:0] ea, eb, oa, ob;
        bit fs;
        de_in = de; hsync_in = hs; vsync_in = vs; pixel_in = pix;
        cent_valid = cv_fire;
        cent_x = cv_fire ? 11'(cv_x) : 11'($urandom);
        cent_y = cv_fire ? 11'(cv_y) : 11'($urandom);
`ifdef CENTROID_BBOX_EN
        bbox_x0 = cv_fire ? 11'(cv_b[0]) : 11'($urandom);
        bbox_y0 = cv_fire ? 11'(cv_b[1]) : 11'($urandom);
        bbox_x1 = cv_fire ? 11'(cv_b[2]) : 11'($urandom);
        bbox_y1 = cv_fire ? 11'(cv_b[3]) : 11'($urandom);
`endif
        ea = {de, hs, vs, exp_pix(2, de, x, y, pix)};
        eb = {de, hs, vs, exp_pix(4, de, x, y, pix)};
        if (de && ea[23:0] == MARK) exp_ma++;
        if (de && eb[23:0] == MARK) exp_mb++;
        if (de && ea[23:0] == BOXC) exp_box++;
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);

        fs = vs && !m_prev_vs;
        if (fs) begin
            m_lock = 1;
            if (cv_fire) begin
                m_sx = cv_x; m_sy = cv_y; m_ever = 1;
                for (int k = 0; k < 4; k++) m_sb[k] = cv_b[k];
            end else if (m_pend) begin
                m_sx = m_px; m_sy = m_py; m_ever = 1;
                for (int k = 0; k < 4; k++) m_sb[k] = m_pb[k];
            end
        end
        if (cv_fire) begin
            m_px = cv_x; m_py = cv_y; m_pend = 1;
            for (int k = 0; k < 4; k++) m_pb[k] = cv_b[k];
        end
        m_prev_vs = vs;

        @(posedge clk);
        #1;
        cv_fire = 0;
        if (exp_a_q.size() > 1) begin
            oa = exp_a_q.pop_front();
            ob = exp_b_q.pop_front();
            check_val("out_a", {5'd0, de_a, hs_a, vs_a, pix_a}, {5'd0, oa});
            check_val("out_b", {5'd0, de_b, hs_b, vs_b, pix_b}, {5'd0, ob});
        end
        if (de_a && pix_a == MARK) obs_ma++;
        if (de_b && pix_b == MARK) obs_mb++;
        if (de_a && pix_a == BOXC) obs_box++;
    endtask

    // One frame: 2 vsync + 2 blank cycles, then lines of HR active pixels and 3 blank.
    task automatic run_frame(input bit with_vs, input int nlines, input int rst_line);
        obs_ma = 0; obs_mb = 0; obs_box = 0; exp_ma = 0; exp_mb = 0; exp_box = 0;
        if (with_vs) begin
            for (int c = 0; c < 4; c++) begin
                maybe_fire(-1, c);
                step(1'b0, 1'b0, logic'(c < 2), rnd_pix(), 0, 0);
            end
        end
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) do_reset(2);
            for (int c = 0; c < HR + 3; c++) begin
                maybe_fire(l, c);
                step(logic'(c < HR), logic'(c == HR + 1), 1'b0, rnd_pix(), c, l);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        do_reset(3);

        // Latency of data and syncs.
        step(1'b1, 1'b1, 1'b0, 24'h123456, 0, 0);
        check_val("lat_de_early", {31'd0, de_a}, 32'd0);
        step(1'b0, 1'b0, 1'b0, rnd_pix(), 0, 0);
        check_val("lat_de", {31'd0, de_a}, 32'd1);
        check_val("lat_pix", {8'd0, pix_a}, 32'h123456);
        check_val("lat_hs", {31'd0, hs_a}, 32'd1);
        step(1'b0, 1'b0, 1'b1, rnd_pix(), 0, 0);
        check_val("lat_vs_early", {31'd0, vs_a}, 32'd0);
        step(1'b0, 1'b0, 1'b0, rnd_pix(), 0, 0);
        check_val("lat_vs", {31'd0, vs_a}, 32'd1);

        // Reset mid-frame, centroid (20,30) strobed afterwards: nothing in this frame.
        sched(0, 40, 5, 20, 30);
        run_frame(1, VR, 20);
        check_val("partial_cnt_a", obs_ma, 0);
        check_val("partial_cnt_b", obs_mb, 0);
        for (int f = 0; f < 2; f++) begin
            run_frame(1, VR, -1);
            check_val("cross_cnt_a", obs_ma, 9);
            check_val("cross_cnt_b", obs_mb, 17);
        end

        // Mid-frame update to (10,10): current frame keeps (20,30).
        sched(0, 40, 5, 10, 10);
        run_frame(1, VR, -1);
        check_val("old_cnt_a", obs_ma, exp_ma);
        check_val("old_cnt_b", obs_mb, 17);
        run_frame(1, VR, -1);
        check_val("new_cnt_a", obs_ma, 9);
        check_val("new_cnt_b", obs_mb, exp_mb);

        // Strobe coincident with frame start to (5,5), plus a later one to (0,63).
        sched(0, -1, 0, 5, 5);
        sched(1, 30, 0, 0, 63);
        run_frame(1, VR, -1);
        check_val("fs_cnt_a", obs_ma, 9);
        check_val("fs_cnt_b", obs_mb, 17);

        // Corner (0,63) with two extra lines past V_RES: clipped arms only.
        run_frame(1, VR + 2, -1);
        check_val("clip_cnt_a", obs_ma, 5);
        check_val("clip_cnt_b", obs_mb, 9);

        // Randomised centroids, strobe timing and boxes.
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 2; s++) begin
                sched(s, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, VR - 1)),
                      0, int'($urandom_range(0, 70)), int'($urandom_range(0, 70)));
                if (sch_l[s] >= 0) sch_c[s] = int'($urandom_range(0, HR + 2));
                for (int k = 0; k < 4; k++) sch_b[s][k] = int'($urandom_range(0, 70));
            end
            run_frame(1, VR, -1);
            check_val("rnd_cnt_a", obs_ma, exp_ma);
            check_val("rnd_cnt_b", obs_mb, exp_mb);
        end

`ifdef CENTROID_BBOX_EN
        sched(0, -1, 0, 40, 40);
        sch_b[0][0] = 2; sch_b[0][1] = 2; sch_b[0][2] = 5; sch_b[0][3] = 4;
        run_frame(1, VR, -1);
        check_val("box_cnt", obs_box, exp_box);
        check_val("box_nonzero", {31'd0, logic'(obs_box > 0)}, 32'd1);
        sched(0, -1, 0, 40, 40);
        sch_b[0][0] = 5; sch_b[0][1] = 2; sch_b[0][2] = 2; sch_b[0][3] = 4;
        run_frame(1, VR, -1);
        check_val("box_swapped_cnt", obs_box, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
